// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
// Command sequencer between the parallel side of an SPI slave and an internal
// single-port byte RAM. Each 10-bit frame carries a 2-bit command and an 8-bit
// payload:
//   00 : load write address        10 : load read address
//   01 : write payload to RAM      11 : fetch byte at read address
// Fetched bytes are presented on tx_data with tx_valid held high until the
// next frame arrives, giving the slave time to shift the byte out on MISO.
//
// Ports
//   clk       in   system clock, rising-edge
//   rst_n     in   asynchronous active-low reset
//   rx_data   in   [9:8] command, [7:0] payload
//   rx_valid  in   one-cycle frame strobe
//   tx_data   out  read byte
//   tx_valid  out  read byte valid (level, held until next frame)
//   busy      out  high while a RAM write or fetch is in progress
//   err_drop  out  one-cycle pulse when a frame arrives while busy
// -----------------------------------------------------------------------------
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       err_drop
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FETCH = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [ADDR_SIZE-1:0]   r_wr_addr;
  logic [ADDR_SIZE-1:0]   r_rd_addr;
  logic [7:0]             r_wdata;
  logic [7:0]             r_tx_data;
  logic                   r_tx_valid;
  logic                   r_err_drop;
  logic [7:0]             r_mem [MEM_DEPTH];

  logic [1:0]             w_cmd;
  logic [7:0]             w_payload;
  logic [ADDR_SIZE-1:0]   w_addr;
  logic                   w_accept;

  assign w_cmd     = rx_data[9:8];
  assign w_payload = rx_data[7:0];
  assign w_addr    = rx_data[ADDR_SIZE-1:0];
  // Frames are decoded only in IDLE and RESP; anything else is dropped.
  assign w_accept  = rx_valid && ((r_state == S_IDLE) || (r_state == S_RESP));

  // Control state, addresses and the registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      r_err_drop <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (rx_valid) begin
            // Any frame releases a held response byte.
            r_tx_valid <= 1'b0;
            case (w_cmd)
              2'b00: begin
                r_wr_addr <= w_addr;
                r_state   <= S_IDLE;
              end
              2'b01: r_state <= S_WRITE;
              2'b10: begin
                r_rd_addr <= w_addr;
                r_state   <= S_IDLE;
              end
              default: r_state <= S_FETCH;
            endcase
          end
        end
        S_WRITE: begin
          if (rx_valid) r_err_drop <= 1'b1;
          if (AUTO_INC != 0) r_wr_addr <= r_wr_addr + 1'b1;
          r_state <= S_IDLE;
        end
        S_FETCH: begin
          if (rx_valid) r_err_drop <= 1'b1;
          r_tx_data  <= r_mem[r_rd_addr];
          r_tx_valid <= 1'b1;
          if (AUTO_INC != 0) r_rd_addr <= r_rd_addr + 1'b1;
          r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write data is captured only when a write frame is accepted; not reset.
  always_ff @(posedge clk) begin
    if (w_accept && (w_cmd == 2'b01)) r_wdata <= w_payload;
  end

  // RAM write port. State is cleared asynchronously, so a reset during WRITE
  // suppresses the pending write; rst_n gating covers a coincident edge.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == S_WRITE)) r_mem[r_wr_addr] <= r_wdata;
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign err_drop = r_err_drop;
  assign busy     = (r_state == S_WRITE) || (r_state == S_FETCH);

endmodule
